// File: rtl/alu_issue_queue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_queue_if
//   Bundles the three buses of the ALU issue queue:
//     in_*   : operation push from the sequencer (valid/ready)
//     alu_*  : registered issue to the 8-bit ALU and its result/flags return
//     out_*  : retirement report (one-cycle out_valid pulse) plus fifo_count
//   modport slave  : the issue queue's view
//   modport master : the environment's view (sequencer + ALU + consumer)
//
//   Handshake: a transfer on the in_* bus happens on every rising clock edge
//   where in_valid && in_ready are both 1. in_valid and the in_* payload may
//   change freely while in_ready is 0; nothing is taken until both are high.
//   The out_* bus has no ready: each out_valid pulse must be consumed.
// ---------------------------------------------------------------------------
interface alu_issue_queue_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [4:0]               in_opcode;
   logic [7:0]               in_operand_a;
   logic [7:0]               in_operand_b;
   logic                     in_use_flags;

   logic                     alu_enable;
   logic                     alu_input_ready;
   logic [4:0]               alu_opcode;
   logic [7:0]               alu_operand_A;
   logic [7:0]               alu_operand_B;
   logic                     alu_carry_in;
   logic                     alu_borrow_in;
   logic                     alu_result_ready;
   logic [7:0]               alu_result;
   logic                     alu_carry_out;
   logic                     alu_borrow_out;
   logic                     alu_zero;
   logic                     alu_negative;
   logic                     alu_overflow;

   logic                     out_valid;
   logic [7:0]               out_result;
   logic [4:0]               out_flags;
   logic [1:0]               out_error;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport slave (
      input  in_valid, in_opcode, in_operand_a, in_operand_b, in_use_flags,
      output in_ready,
      output alu_enable, alu_input_ready, alu_opcode, alu_operand_A, alu_operand_B,
             alu_carry_in, alu_borrow_in,
      input  alu_result_ready, alu_result, alu_carry_out, alu_borrow_out,
             alu_zero, alu_negative, alu_overflow,
      output out_valid, out_result, out_flags, out_error, fifo_count
   );

   modport master (
      output in_valid, in_opcode, in_operand_a, in_operand_b, in_use_flags,
      input  in_ready,
      input  alu_enable, alu_input_ready, alu_opcode, alu_operand_A, alu_operand_B,
             alu_carry_in, alu_borrow_in,
      output alu_result_ready, alu_result, alu_carry_out, alu_borrow_out,
             alu_zero, alu_negative, alu_overflow,
      input  out_valid, out_result, out_flags, out_error, fifo_count
   );
endinterface

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//   Issue stage in front of the 8-bit ALU. Operations are buffered in a
//   DEPTH-entry FIFO, issued one at a time (IDLE -> ISSUE -> WAIT), and
//   retired with result, error code and the architectural flag register
//   {C,B,Z,N,V}. C/B are fed back as carry_in/borrow_in when the op asks
//   for it, which lets the sequencer chain multi-byte arithmetic.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   bus        : alu_issue_queue_if.slave (in_*, alu_*, out_*, fifo_count)
//   dbg_state  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
// ---------------------------------------------------------------------------
module alu_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int NUM_OPS = 20,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_issue_queue_if.slave     bus,
   output logic [1:0]           dbg_state
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic [7:0] a;
      logic [7:0] b;
      logic       use_flags;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [4:0]      alu_opcode_q, alu_opcode_d;
   logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic            alu_cin_q, alu_cin_d, alu_bin_q, alu_bin_d;
   logic            alu_enable_q, alu_enable_d;
   logic [4:0]      flags_q, flags_d;       // {C,B,Z,N,V}
   logic            out_valid_q, out_valid_d;
   logic [7:0]      out_result_q, out_result_d;
   logic [1:0]      out_error_q, out_error_d;

   logic            in_ready;
   logic            push, pop, legal;
   entry_t          head;

   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = bus.in_valid && in_ready;
   // The FIFO head is only consumed while the FSM is free to take it.
   assign pop      = (state_q == S_IDLE) && (count_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign legal    = int'({27'd0, head.opcode}) < NUM_OPS;

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      state_d      = state_q;
      timer_d      = timer_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cin_d    = alu_cin_q;
      alu_bin_d    = alu_bin_q;
      alu_enable_d = 1'b1;
      flags_d      = flags_q;
      out_valid_d  = 1'b0;
      out_result_d = out_result_q;
      out_error_d  = out_error_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{opcode: bus.in_opcode, a: bus.in_operand_a,
                             b: bus.in_operand_b, use_flags: bus.in_use_flags};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (legal) begin
                  alu_opcode_d = head.opcode;
                  alu_a_d      = head.a;
                  alu_b_d      = head.b;
                  alu_cin_d    = head.use_flags & flags_q[4];
                  alu_bin_d    = head.use_flags & flags_q[3];
                  state_d      = S_ISSUE;
               end else begin
                  // Rejected without touching the ALU or the flag register.
                  out_valid_d  = 1'b1;
                  out_error_d  = 2'b01;
                  out_result_d = 8'd0;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            timer_d = '0;
         end
         S_WAIT: begin
            if (bus.alu_result_ready) begin
               out_result_d = bus.alu_result;
               flags_d      = {bus.alu_carry_out, bus.alu_borrow_out, bus.alu_zero,
                               bus.alu_negative, bus.alu_overflow};
               out_valid_d  = 1'b1;
               out_error_d  = 2'b00;
               state_d      = S_IDLE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               out_valid_d  = 1'b1;
               out_error_d  = 2'b10;
               out_result_d = 8'd0;
               state_d      = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Storage carries no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= S_IDLE;
         timer_q      <= '0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         alu_bin_q    <= 1'b0;
         alu_enable_q <= 1'b0;
         flags_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_error_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         timer_q      <= timer_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         alu_bin_q    <= alu_bin_d;
         alu_enable_q <= alu_enable_d;
         flags_q      <= flags_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_error_q  <= out_error_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.alu_enable      = alu_enable_q;
   assign bus.alu_input_ready = (state_q == S_ISSUE);
   assign bus.alu_opcode      = alu_opcode_q;
   assign bus.alu_operand_A   = alu_a_q;
   assign bus.alu_operand_B   = alu_b_q;
   assign bus.alu_carry_in    = alu_cin_q;
   assign bus.alu_borrow_in   = alu_bin_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_result      = out_result_q;
   assign bus.out_flags       = flags_q;
   assign bus.out_error       = out_error_q;
   assign bus.fifo_count      = count_q;
   assign dbg_state           = state_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
//   Directed bench for alu_issue_queue. Inputs change 1 time unit after the
//   rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_fail;
   int         strobe_cnt;
   int         ov_cnt;
   int         s0, o0;

   alu_issue_queue_if #(.DEPTH(4)) bus ();

   alu_issue_queue #(.DEPTH(4), .NUM_OPS(20), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---- clock / reset ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Event counters sampled mid-cycle.
   initial begin
      strobe_cnt = 0;
      ov_cnt     = 0;
   end
   always @(negedge clk) begin
      if (bus.alu_input_ready === 1'b1) strobe_cnt = strobe_cnt + 1;
      if (bus.out_valid === 1'b1)       ov_cnt     = ov_cnt + 1;
   end

   // ---- driver / checker tasks ----
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic uf);
      bus.in_valid     = 1'b1;
      bus.in_opcode    = op;
      bus.in_operand_a = a;
      bus.in_operand_b = b;
      bus.in_use_flags = uf;
      tick();
      bus.in_valid     = 1'b0;
   endtask

   // Acts as the ALU for one op: waits for the issue strobe (unless the op is
   // already in WAIT), checks the issued fields, returns res/fl after lat cycles
   // and checks the retirement report.
   task automatic serve(input bit skip, input int lat, input logic [4:0] e_op,
                        input logic [7:0] e_a, input logic [7:0] e_b,
                        input logic e_cin, input logic e_bin,
                        input logic [7:0] res, input logic [4:0] fl);
      int n;
      if (!skip) begin
         n = 0;
         while (bus.alu_input_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
         check("issue_strobe", bus.alu_input_ready, 1);
      end else begin
         check("in_wait_state", dbg_state, 2);
      end
      check("alu_opcode", bus.alu_opcode, e_op);
      check("alu_operand_A", bus.alu_operand_A, e_a);
      check("alu_operand_B", bus.alu_operand_B, e_b);
      check("alu_carry_in", bus.alu_carry_in, e_cin);
      check("alu_borrow_in", bus.alu_borrow_in, e_bin);
      if (!skip) begin
         tick();
         repeat (lat - 1) tick();
      end
      bus.alu_result_ready = 1'b1;
      bus.alu_result       = res;
      {bus.alu_carry_out, bus.alu_borrow_out, bus.alu_zero,
       bus.alu_negative, bus.alu_overflow} = fl;
      tick();
      bus.alu_result_ready = 1'b0;
      check("ret_out_valid", bus.out_valid, 1);
      check("ret_out_result", bus.out_result, res);
      check("ret_out_flags", bus.out_flags, fl);
      check("ret_out_error", bus.out_error, 0);
   endtask

   // ---- directed sequence ----
   initial begin
      n_checks             = 0;
      n_fail               = 0;
      rst                  = 1'b1;
      bus.in_valid         = 1'b0;
      bus.in_opcode        = '0;
      bus.in_operand_a     = '0;
      bus.in_operand_b     = '0;
      bus.in_use_flags     = 1'b0;
      bus.alu_result_ready = 1'b0;
      bus.alu_result       = '0;
      bus.alu_carry_out    = 1'b0;
      bus.alu_borrow_out   = 1'b0;
      bus.alu_zero         = 1'b0;
      bus.alu_negative     = 1'b0;
      bus.alu_overflow     = 1'b0;

      // 1 reset
      tick();
      tick();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_flags", bus.out_flags, 0);
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_alu_enable", bus.alu_enable, 0);
      check("rst_strobe", bus.alu_input_ready, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      check("enable_low_after_rst", bus.alu_enable, 0);
      tick();
      check("enable_high", bus.alu_enable, 1);

      // 2 single op: 127 + 126 overflows to 0xFD
      s0 = strobe_cnt;
      o0 = ov_cnt;
      push(5'd0, 8'd127, 8'd126, 1'b0);
      check("single_count", bus.fifo_count, 1);
      serve(1'b0, 1, 5'd0, 8'd127, 8'd126, 1'b0, 1'b0, 8'hFD, 5'b00011);
      check("single_flag_v", bus.out_flags[0], 1);
      tick();
      check("single_pulse_end", bus.out_valid, 0);
      check("single_result_hold", bus.out_result, 8'hFD);
      check("single_one_strobe", strobe_cnt - s0, 1);
      check("single_one_retire", ov_cnt - o0, 1);

      // 3 carry chain
      push(5'd1, 8'hFF, 8'h01, 1'b0);
      serve(1'b0, 1, 5'd1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 5'b10100);
      push(5'd2, 8'h12, 8'h34, 1'b0);
      serve(1'b0, 2, 5'd2, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 5'b10000);
      push(5'd2, 8'h01, 8'h00, 1'b1);
      serve(1'b0, 1, 5'd2, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 5'b01000);
      push(5'd3, 8'h00, 8'h01, 1'b1);
      serve(1'b0, 3, 5'd3, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFE, 5'b00000);

      // 4 full FIFO with the ALU stalled; second push coincides with the pop
      push(5'd4, 8'h10, 8'h01, 1'b0);
      check("fill_count1", bus.fifo_count, 1);
      push(5'd5, 8'h20, 8'h02, 1'b0);
      check("fill_pushpop_count", bus.fifo_count, 1);
      push(5'd6, 8'h30, 8'h03, 1'b0);
      check("fill_count2", bus.fifo_count, 2);
      push(5'd7, 8'h40, 8'h04, 1'b0);
      check("fill_count3", bus.fifo_count, 3);
      push(5'd8, 8'h50, 8'h05, 1'b0);
      check("fill_count4", bus.fifo_count, 4);
      check("full_in_ready", bus.in_ready, 0);
      bus.in_valid     = 1'b1;
      bus.in_opcode    = 5'd9;
      bus.in_operand_a = 8'h60;
      bus.in_operand_b = 8'h06;
      bus.in_use_flags = 1'b0;
      tick();
      tick();
      check("full_held_count", bus.fifo_count, 4);
      bus.in_valid = 1'b0;
      serve(1'b1, 1, 5'd4, 8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 5'b00000);
      serve(1'b0, 1, 5'd5, 8'h20, 8'h02, 1'b0, 1'b0, 8'h22, 5'b00000);
      serve(1'b0, 1, 5'd6, 8'h30, 8'h03, 1'b0, 1'b0, 8'h33, 5'b00000);
      serve(1'b0, 1, 5'd7, 8'h40, 8'h04, 1'b0, 1'b0, 8'h44, 5'b00000);
      serve(1'b0, 1, 5'd8, 8'h50, 8'h05, 1'b0, 1'b0, 8'h55, 5'b10010);
      tick();
      tick();
      check("drain_count", bus.fifo_count, 0);
      check("drain_idle", dbg_state, 0);

      // 5 illegal opcodes 25 and 20 (first illegal), then 19 (last legal)
      s0 = strobe_cnt;
      push(5'd25, 8'hAA, 8'hBB, 1'b1);
      tick();
      check("ill25_valid", bus.out_valid, 1);
      check("ill25_error", bus.out_error, 1);
      check("ill25_result", bus.out_result, 0);
      check("ill25_flags", bus.out_flags, 5'b10010);
      push(5'd20, 8'hAA, 8'hBB, 1'b0);
      tick();
      check("ill20_valid", bus.out_valid, 1);
      check("ill20_error", bus.out_error, 1);
      check("ill_no_strobe", strobe_cnt - s0, 0);
      push(5'd19, 8'h3C, 8'h42, 1'b1);
      serve(1'b0, 1, 5'd19, 8'h3C, 8'h42, 1'b1, 1'b0, 8'h7E, 5'b01001);

      // result_ready outside WAIT is ignored
      tick();
      o0 = ov_cnt;
      bus.alu_result_ready = 1'b1;
      bus.alu_result       = 8'hC3;
      {bus.alu_carry_out, bus.alu_borrow_out, bus.alu_zero,
       bus.alu_negative, bus.alu_overflow} = 5'b11111;
      tick();
      tick();
      bus.alu_result_ready = 1'b0;
      tick();
      check("stray_no_retire", ov_cnt - o0, 0);
      check("stray_result_hold", bus.out_result, 8'h7E);
      check("stray_flags_hold", bus.out_flags, 5'b01001);

      // 6 timeout: 16 cycles in WAIT without ready
      push(5'd3, 8'h01, 8'h02, 1'b1);
      tick();
      check("to_strobe", bus.alu_input_ready, 1);
      check("to_carry_in", bus.alu_carry_in, 0);
      check("to_borrow_in", bus.alu_borrow_in, 1);
      tick();
      repeat (15) tick();
      check("to_not_yet", bus.out_valid, 0);
      check("to_still_wait", dbg_state, 2);
      tick();
      check("to_valid", bus.out_valid, 1);
      check("to_error", bus.out_error, 2);
      check("to_result", bus.out_result, 0);
      check("to_flags", bus.out_flags, 5'b01001);
      check("to_idle", dbg_state, 0);

      // reset mid-WAIT with one more op still queued
      push(5'd4, 8'h05, 8'h06, 1'b0);
      push(5'd5, 8'h07, 8'h08, 1'b0);
      tick();
      tick();
      check("mid_wait_state", dbg_state, 2);
      o0 = ov_cnt;
      rst = 1'b1;
      tick();
      tick();
      check("mrst_count", bus.fifo_count, 0);
      check("mrst_state", dbg_state, 0);
      check("mrst_in_ready", bus.in_ready, 1);
      check("mrst_flags", bus.out_flags, 0);
      check("mrst_enable", bus.alu_enable, 0);
      rst                  = 1'b0;
      bus.alu_result_ready = 1'b1;
      bus.alu_result       = 8'h99;
      tick();
      bus.alu_result_ready = 1'b0;
      tick();
      tick();
      check("late_no_retire", ov_cnt - o0, 0);
      check("late_result", bus.out_result, 0);
      check("late_flags", bus.out_flags, 0);
      check("late_count", bus.fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
